// File: rtl/jtframe_rom_prog_pkg.sv
// Shared definitions for the ROM download programmer and its bank mapper.
package jtframe_rom_pkg;

    localparam int BANK_CNT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } prog_st_t;

    // Active-low byte enables on the 16-bit SDRAM word
    localparam logic [1:0] MASK_LO = 2'b10;
    localparam logic [1:0] MASK_HI = 2'b01;

endpackage

// File: rtl/jtframe_rom_prog_if.sv
// SDRAM program-write port: request fields plus the ack/rdy handshake.
interface jtframe_rom_prog_if;

    logic        prog_we;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_ack;
    logic        prog_rdy;

    modport master (
        output prog_we, prog_addr, prog_data, prog_mask, prog_ba,
        input  prog_ack, prog_rdy
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_mask, prog_ba,
        output prog_ack, prog_rdy
    );

endinterface

// File: rtl/jtframe_rom_prog_bankmap.sv
// Byte address to SDRAM bank and in-bank offset; highest matching start wins.
module jtframe_rom_bankmap #(
    parameter int OFFW = 27
) (
    input  logic [26:0]     addr,
    input  logic [26:0]     ba1_start,
    input  logic [26:0]     ba2_start,
    input  logic [26:0]     ba3_start,
    output logic [1:0]      ba,
    output logic [OFFW-1:0] off
);

    always_comb begin
        ba  = 2'd0;
        off = addr[OFFW-1:0];
        if (addr >= ba3_start) begin
            ba  = 2'd3;
            off = OFFW'(addr - ba3_start);
        end else if (addr >= ba2_start) begin
            ba  = 2'd2;
            off = OFFW'(addr - ba2_start);
        end else if (addr >= ba1_start) begin
            ba  = 2'd1;
            off = OFFW'(addr - ba1_start);
        end
    end

endmodule

// File: rtl/jtframe_rom_prog.sv
// Turns the download byte stream into masked 16-bit SDRAM program writes,
// with a one-entry skid buffer, rdy timeout and upstream busy indication.
module jtframe_rom_prog
    import jtframe_rom_pkg::*;
#(
    parameter logic [26:0] BA1_START = 27'h10_0000,
    parameter logic [26:0] BA2_START = 27'h20_0000,
    parameter logic [26:0] BA3_START = 27'h30_0000,
    parameter bit          SWAB      = 1'b0,
    parameter int          TOW       = 6
) (
    input  logic               rst,
    input  logic               clk,
    input  logic               downloading,
    input  logic               ioctl_rom_wr,
    input  logic [26:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    jtframe_rom_prog_if.master prog,
    output logic               dwnld_busy,
    output logic               overflow,
    output logic               timeout
);

    // Timer loads one short of all-ones so WAIT lasts 2^TOW-1 cycles in total
    localparam logic [TOW-1:0] TO_LOAD = {{(TOW-1){1'b1}}, 1'b0};

    prog_st_t        st, st_nx;
    logic            issue, to_hit, enter_wait;
    logic            skid_v, skid_pop, skid_load, drop;
    logic [26:0]     skid_addr;
    logic [7:0]      skid_dout;
    logic [26:0]     src_addr;
    logic [7:0]      src_dout;
    logic [1:0]      map_ba;
    logic [22:0]     map_off;
    logic [TOW-1:0]  to_cnt;
    logic            dl_l, dl_rise;
    logic [21:0]     addr_r;
    logic [15:0]     data_r;
    logic [1:0]      mask_r, ba_r;

    assign src_addr = skid_v ? skid_addr : ioctl_addr;
    assign src_dout = skid_v ? skid_dout : ioctl_dout;

    jtframe_rom_bankmap #(.OFFW(23)) u_bankmap (
        .addr      (src_addr),
        .ba1_start (BA1_START),
        .ba2_start (BA2_START),
        .ba3_start (BA3_START),
        .ba        (map_ba),
        .off       (map_off)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx      = st;
        issue      = 1'b0;
        to_hit     = 1'b0;
        enter_wait = 1'b0;
        case (st)
            IDLE: if (skid_v || ioctl_rom_wr) begin
                st_nx = REQ;
                issue = 1'b1;
            end
            REQ: if (prog.prog_ack) begin
                st_nx      = WAIT;
                enter_wait = 1'b1;
            end
            WAIT: if (prog.prog_rdy) begin
                st_nx = IDLE;
            end else if (to_cnt == '0) begin
                st_nx  = IDLE;
                to_hit = 1'b1;
            end
            default: st_nx = IDLE;
        endcase
    end

    // Skid: pop and push may coincide; a byte is only lost when full and busy
    assign skid_pop  = (st == IDLE) && skid_v;
    assign skid_load = ioctl_rom_wr && ((st != IDLE) || skid_v) && (!skid_v || skid_pop);
    assign drop      = ioctl_rom_wr && skid_v && !skid_pop;
    assign dl_rise   = downloading && !dl_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_v    <= 1'b0;
            skid_addr <= '0;
            skid_dout <= '0;
        end else if (skid_load) begin
            skid_v    <= 1'b1;
            skid_addr <= ioctl_addr;
            skid_dout <= ioctl_dout;
        end else if (skid_pop) begin
            skid_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= '0;
            data_r <= '0;
            mask_r <= '0;
            ba_r   <= '0;
        end else if (issue) begin
            addr_r <= map_off[22:1];
            data_r <= {src_dout, src_dout};
            mask_r <= (map_off[0] ^ SWAB) ? MASK_HI : MASK_LO;
            ba_r   <= map_ba;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (enter_wait) begin
            to_cnt <= TO_LOAD;
        end else if (st == WAIT && to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_l       <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            dwnld_busy <= 1'b0;
        end else begin
            dl_l       <= downloading;
            overflow   <= (overflow && !dl_rise) || drop;
            timeout    <= (timeout  && !dl_rise) || to_hit;
            dwnld_busy <= downloading || (st != IDLE) || skid_v;
        end
    end

    assign prog.prog_we   = (st == REQ);
    assign prog.prog_addr = addr_r;
    assign prog.prog_data = data_r;
    assign prog.prog_mask = mask_r;
    assign prog.prog_ba   = ba_r;

endmodule

// File: doc/jtframe_rom_prog.md
Name: jtframe_rom_prog

Overview:
- Downstream stage of the MiSTer download mux.
- Consumes the byte stream ioctl_rom_wr/ioctl_addr/ioctl_dout, whether it comes from the HPS or from a DDR dump.
- Maps each byte to an SDRAM bank and word address, and issues one masked 16-bit program write per byte to the SDRAM controller.
- Returns dwnld_busy upstream so the download window closes only after the last write has completed.

Parameters:
- BA1_START, 27'h10_0000: first byte address mapped to bank 1.
- BA2_START, 27'h20_0000: first byte address mapped to bank 2.
- BA3_START, 27'h30_0000: first byte address mapped to bank 3.
- SWAB, 0: when 1, an even address goes to the high byte.
- TOW, 6: width of the prog_rdy timeout counter.

Ports:
- rst  in  1  reset, asynchronous, active-high.
- clk  in  1  clock.
- downloading  in  1  download window from the upstream stage.
- ioctl_rom_wr  in  1  byte strobe, single cycle.
- ioctl_addr  in  27  byte address.
- ioctl_dout  in  8  byte data.
- prog_we  out  1  write request to SDRAM.
- prog_addr  out  22  word address within the bank.
- prog_data  out  16  byte replicated on both halves.
- prog_mask  out  2  active-low byte enable.
- prog_ba  out  2  bank.
- prog_ack  in  1  SDRAM accepted the request.
- prog_rdy  in  1  SDRAM finished the write.
- dwnld_busy  out  1  block has pending work.
- overflow  out  1  sticky flag: a byte was dropped.
- timeout  out  1  sticky flag: prog_rdy never arrived.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; skid register empty.
- Bank map, by priority:
  - addr >= BA3_START: ba=3, off = addr - BA3_START.
  - addr >= BA2_START: ba=2, off = addr - BA2_START.
  - addr >= BA1_START: ba=1, off = addr - BA1_START.
  - otherwise: ba=0, off = addr.
- Address and data: prog_addr = off[22:1]; higher offset bits are truncated, so the address wraps modulo 4M words. prog_data = {dout,dout}.
- Mask:
  - prog_mask = off[0]^SWAB ? 2'b01 : 2'b10 (0 enables the byte).
  - SWAB=0 and off even: low byte written, mask 2'b10.
- FSM states:
  - IDLE: on a source byte, register addr/ba/data/mask, assert prog_we, go to REQ.
  - REQ: hold prog_we and all prog_* outputs stable until prog_ack is sampled high. Drop prog_we in the cycle after that, then go to WAIT.
  - WAIT: leave on prog_rdy, or when the TOW-bit counter saturates (2^TOW-1 cycles). The timeout exit sets the timeout flag. Go to IDLE.
- Latency: ioctl_rom_wr at cycle N gives prog_we=1 at N+1 when IDLE and the skid register is empty.
- Source priority in IDLE: the skid byte beats a live ioctl byte.
- Skid register (one entry): an incoming byte is stored there when the FSM is not IDLE or the skid is occupied. Pop and push may happen in the same cycle; the new byte replaces the popped one.
- Skid full plus a new byte while the FSM is busy: the byte is dropped and overflow is set.
- overflow and timeout clear on the rising edge of downloading.
- dwnld_busy = downloading | FSM!=IDLE | skid valid, registered. It falls exactly 1 cycle after all three go low.
- ioctl_rom_wr while downloading is low is still processed, since upstream owns the gating.
- prog_ack arriving in the same cycle prog_we rises is legal; prog_we is then high for exactly 1 cycle.
- prog_rdy while in REQ is ignored.
- rst mid-write: immediate return to IDLE and prog_we=0; the pending byte is lost.

Decomposition:
- Shared package jtframe_rom_pkg holds:
  - bank-count constant (4);
  - FSM state typedef (IDLE/REQ/WAIT);
  - mask encodings MASK_LO=2'b10 and MASK_HI=2'b01.
- Combinational sub-module jtframe_rom_bankmap (addr + starts -> ba, off) is reused by the MiST/SiDi targets.
- FSM, skid register and flags stay in the top module.

Test Plan:
- Single byte: addr 27'h000005, data 8'hA5, ack after 2 cycles, rdy after 4 -> prog_ba=0, prog_addr=2, prog_data=16'hA5A5, mask=2'b01; prog_we held 3 cycles.
- Bank boundaries: addr 27'h0FFFFF / 27'h100000 / 27'h300001 -> ba 0/1/3 with prog_addr 22'h07FFFF / 0 / 0; masks 01 / 10 / 01.
- Back-to-back: bytes on 3 consecutive cycles with ack=1 and rdy 1 cycle later:
  - the second byte is held in the skid register;
  - the third byte is dropped and overflow=1;
  - a new downloading rising edge clears overflow.
- Timeout: prog_rdy held 0 with TOW=6 -> FSM returns to IDLE 63 cycles after entering WAIT, timeout=1, and the next queued byte is issued.
- dwnld_busy: downloading falls while WAIT is active -> busy stays 1 until rdy, falls 1 cycle after IDLE.
- Reset: rst pulsed during REQ -> prog_we=0 the same cycle, dwnld_busy=0, and the next byte after release is processed normally.
